// File: rtl/xcache_param_pkg.sv
// Shared xcache parameters and the request-routing types used by the
// request router and the write-back path.
package xcache_param_pkg;

  localparam int XMEM_AW            = 32;
  localparam int MAX_PARTITION      = 4;
  localparam int LOG2_MAX_PARTITION = 2;

  localparam string RANGE_SCALAR = "SCALAR";
  localparam string RANGE_ARRAY  = "ARRAY";
  localparam string RANGE_CYCLIC = "CYCLIC";

  // The tag field is sized for the widest supported ID; users keep the low ID_W bits.
  localparam int ROUTE_ID_MAX_W = 16;

  typedef struct packed {
    logic [XMEM_AW-1:0]        adr;
    logic                      we;
    logic [ROUTE_ID_MAX_W-1:0] id;
  } route_req_t;

endpackage

// File: rtl/xcache_req_route_if.sv
// Request-in / routed-request-out bundle of the xcache request router.
interface xcache_req_route_if
  import xcache_param_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int BANK_W = 2
);
  // Handshake on both sides: a transfer happens on a rising clk edge where
  // valid & ready are both 1; valid never waits on ready, and payload is
  // held stable while valid is 1 and ready is 0.
  logic                          in_valid;
  logic                          in_ready;
  logic [XMEM_AW-1:0]            in_adr;
  logic                          in_we;
  logic [ID_W-1:0]               in_id;

  logic                          out_valid;
  logic                          out_ready;
  logic [XMEM_AW-1:0]            out_adr;
  logic [LOG2_MAX_PARTITION-1:0] out_partIdx;
  logic [BANK_W-1:0]             out_bankSel;
  logic                          out_miss;
  logic                          out_we;
  logic [ID_W-1:0]               out_id;

  modport master (
    output in_valid, in_adr, in_we, in_id, out_ready,
    input  in_ready, out_valid, out_adr, out_partIdx, out_bankSel, out_miss, out_we, out_id
  );

  modport slave (
    input  in_valid, in_adr, in_we, in_id, out_ready,
    output in_ready, out_valid, out_adr, out_partIdx, out_bankSel, out_miss, out_we, out_id
  );

endinterface

// File: rtl/xcache_part_prienc.sv
// Partition match vector to index priority encoder; lowest set bit wins.
module xcache_part_prienc #(
  parameter int NUM   = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM-1:0]   match,
  output logic [IDX_W-1:0] idx,
  output logic             miss
);

  // Scan downward so the lowest matching index is the last to be written.
  always_comb begin
    idx  = '0;
    miss = 1'b1;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx  = IDX_W'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xcache_req_route.sv
// Two-stage request router: S1 registers the request and its partition match
// vector, S2 resolves partition/bank into the registered output bundle.
module xcache_req_route
  import xcache_param_pkg::*;
#(
  parameter string RANGE_TYPE = "SCALAR",
  parameter int    NUM_BANK   = 4,
  parameter int    ID_W       = 4,
  localparam int   BANK_W     = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  xcache_req_route_if.slave        bus,
  input  logic [XMEM_AW-1:0]       rangeStart [MAX_PARTITION],
  input  logic [XMEM_AW-1:0]       rangeEnd   [MAX_PARTITION],
  input  logic [MAX_PARTITION-1:0] partEn,
  output logic                     busy
);

  route_req_t                      inReq, s1Req;
  logic [MAX_PARTITION-1:0]        inMatch, s1Match;
  logic                            s1V, outV, s2Adv, inReadyInt;
  logic [LOG2_MAX_PARTITION-1:0]   resIdx;
  logic                            resMiss;
  logic [BANK_W-1:0]               resBank;
  logic                            unusedIdBits;

  assign inReq = '{adr: bus.in_adr, we: bus.in_we, id: ROUTE_ID_MAX_W'(bus.in_id)};
  assign unusedIdBits = ^s1Req.id;

  // Config is sampled here only; rangeEnd == 0 naturally never matches.
  always_comb begin
    inMatch = '0;
    for (int i = 0; i < MAX_PARTITION; i++) begin
      inMatch[i] = partEn[i] & (bus.in_adr >= rangeStart[i]) & (bus.in_adr < rangeEnd[i]);
    end
  end

  generate
    if (RANGE_TYPE == RANGE_SCALAR) begin : g_scalar
      xcache_part_prienc #(
        .NUM   (MAX_PARTITION),
        .IDX_W (LOG2_MAX_PARTITION)
      ) u_prienc (
        .match (s1Match),
        .idx   (resIdx),
        .miss  (resMiss)
      );
    end else begin : g_unpart
      logic unusedMatch;
      assign unusedMatch = ^s1Match;
      assign resIdx      = '0;
      assign resMiss     = 1'b0;
    end

    if (NUM_BANK > 1) begin : g_bank
      assign resBank = s1Req.adr[2 +: BANK_W];
    end else begin : g_onebank
      assign resBank = '0;
    end
  endgenerate

  // Each stage advances when empty or when its content leaves this cycle.
  assign s2Adv      = !outV | bus.out_ready;
  assign inReadyInt = !s1V | s2Adv;
  assign bus.in_ready  = inReadyInt;
  assign bus.out_valid = outV;
  assign busy          = s1V | outV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1V             <= 1'b0;
      s1Req           <= '0;
      s1Match         <= '0;
      outV            <= 1'b0;
      bus.out_adr     <= '0;
      bus.out_partIdx <= '0;
      bus.out_bankSel <= '0;
      bus.out_miss    <= 1'b0;
      bus.out_we      <= 1'b0;
      bus.out_id      <= '0;
    end else begin
      if (inReadyInt) begin
        s1V <= bus.in_valid;
        if (bus.in_valid) begin
          s1Req   <= inReq;
          s1Match <= inMatch;
        end
      end
      if (s2Adv) begin
        outV <= s1V;
        if (s1V) begin
          bus.out_adr     <= s1Req.adr;
          bus.out_partIdx <= resIdx;
          bus.out_bankSel <= resBank;
          bus.out_miss    <= resMiss;
          bus.out_we      <= s1Req.we;
          bus.out_id      <= s1Req.id[ID_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_xcache_req_route.sv
// Directed bench for xcache_req_route: one SCALAR and one ARRAY instance.
module tb_xcache_req_route;
  import xcache_param_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] rangeStart [4];
  logic [31:0] rangeEnd   [4];
  logic [3:0]  partEn;
  logic        busyS, busyA;
  int          checks;
  int          errors;
  logic [5:0]  exp_q[$];

  xcache_req_route_if #(.ID_W(4), .BANK_W(2)) ifS ();
  xcache_req_route_if #(.ID_W(4), .BANK_W(2)) ifA ();

  xcache_req_route #(.RANGE_TYPE("SCALAR"), .NUM_BANK(4), .ID_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(ifS.slave),
    .rangeStart(rangeStart), .rangeEnd(rangeEnd), .partEn(partEn), .busy(busyS)
  );

  xcache_req_route #(.RANGE_TYPE("ARRAY"), .NUM_BANK(4), .ID_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifA.slave),
    .rangeStart(rangeStart), .rangeEnd(rangeEnd), .partEn(partEn), .busy(busyA)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_part(input int p, input logic [31:0] s, input logic [31:0] e);
    rangeStart[p] = s;
    rangeEnd[p]   = e;
  endtask

  // Inputs change only on negedge; outputs are sampled on negedge.
  task automatic send_single(input logic [31:0] adr, input logic [3:0] id,
                             input logic [1:0] expIdx, input logic [1:0] expBank,
                             input logic expMiss, input string name);
    ifS.in_valid = 1'b1; ifS.in_adr = adr; ifS.in_id = id; ifS.in_we = id[0];
    @(negedge clk);
    ifS.in_valid = 1'b0;
    checks++;
    if (ifS.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_latency: out_valid=%b one cycle after accept, required 0", name, ifS.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({ifS.out_valid, ifS.out_partIdx, ifS.out_bankSel, ifS.out_miss, ifS.out_id, ifS.out_we, ifS.out_adr}
        !== {1'b1, expIdx, expBank, expMiss, id, id[0], adr}) begin
      errors++;
      $display("FAIL %s: got v=%b idx=%0d bank=%0d miss=%b id=%0d we=%b adr=%h, required v=1 idx=%0d bank=%0d miss=%b id=%0d we=%b adr=%h",
               name, ifS.out_valid, ifS.out_partIdx, ifS.out_bankSel, ifS.out_miss, ifS.out_id, ifS.out_we,
               ifS.out_adr, expIdx, expBank, expMiss, id, id[0], adr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({ifS.out_valid, ifS.in_ready, busyS, ifS.out_id, ifS.out_adr, ifS.out_miss, ifS.out_partIdx, ifS.out_bankSel}
        !== {1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b busy=%b id=%0d adr=%h miss=%b, required v=0 rdy=1 busy=0 id=0 adr=0 miss=0",
               ifS.out_valid, ifS.in_ready, busyS, ifS.out_id, ifS.out_adr, ifS.out_miss);
    end
  endtask

  task automatic test_lookup();
    set_part(0, 32'h0000, 32'h1000);
    set_part(1, 32'h1000, 32'h2000);
    set_part(2, 32'h0000, 32'h0000);
    set_part(3, 32'h0000, 32'h0000);
    partEn = 4'b0011;
    send_single(32'h1008, 4'd3, 2'd1, 2'd2, 1'b0, "hit_part1");
    partEn = 4'b1111;
    send_single(32'h3000, 4'd4, 2'd0, 2'd0, 1'b1, "miss_outside");
    partEn = 4'b0001;
    send_single(32'h1004, 4'd5, 2'd0, 2'd1, 1'b1, "miss_disabled");
    partEn = 4'b0011;
    send_single(32'h0FFC, 4'd7, 2'd0, 2'd3, 1'b0, "below_boundary");
    send_single(32'h1000, 4'd8, 2'd1, 2'd0, 1'b0, "start_inclusive");
    send_single(32'h2000, 4'd9, 2'd0, 2'd0, 1'b1, "end_exclusive");
  endtask

  task automatic test_overlap();
    set_part(0, 32'h0000, 32'h2000);
    set_part(1, 32'h1000, 32'h2000);
    partEn = 4'b0011;
    send_single(32'h1800, 4'd6, 2'd0, 2'd0, 1'b0, "overlap_low_wins");
    set_part(0, 32'h0000, 32'h1000);
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    for (int cyc = 0; cyc < 12; cyc++) begin
      checks++;
      if (ifS.out_valid !== (cyc >= 2 && cyc <= 9)) begin
        errors++; $display("FAIL stream_valid_c%0d: out_valid=%b, required %b", cyc, ifS.out_valid, (cyc >= 2 && cyc <= 9));
      end
      if (ifS.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra_c%0d: unexpected output id=%0d", cyc, ifS.out_id);
        end else begin
          e = exp_q.pop_front();
          if ({ifS.out_bankSel, ifS.out_id} !== e) begin
            errors++;
            $display("FAIL stream_data_c%0d: bank=%0d id=%0d, required bank=%0d id=%0d",
                     cyc, ifS.out_bankSel, ifS.out_id, e[5:4], e[3:0]);
          end
        end
      end
      if (cyc < 8) begin
        ifS.in_valid = 1'b1; ifS.in_adr = 32'(cyc * 4); ifS.in_id = 4'(cyc); ifS.in_we = 1'b0;
        exp_q.push_back({2'(cyc % 4), 4'(cyc)});
        #1;
        checks++;
        if (ifS.in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_ready_c%0d: in_ready=%b, required 1", cyc, ifS.in_ready);
        end
      end else begin
        ifS.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stream_drained: %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    ifS.out_ready = 1'b0;
    ifS.in_valid = 1'b1; ifS.in_adr = 32'h0010; ifS.in_id = 4'd10; ifS.in_we = 1'b0;
    @(negedge clk);
    ifS.in_adr = 32'h0014; ifS.in_id = 4'd11;
    @(negedge clk);
    ifS.in_adr = 32'h0018; ifS.in_id = 4'd12;
    #1;
    checks++;
    if (ifS.in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready: in_ready=%b, required 0", ifS.in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({ifS.out_valid, ifS.out_id, ifS.out_adr, ifS.out_bankSel, ifS.in_ready} !== {1'b1, 4'd10, 32'h0010, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold_%0d: v=%b id=%0d adr=%h bank=%0d rdy=%b, required v=1 id=10 adr=00000010 bank=0 rdy=0",
                 k, ifS.out_valid, ifS.out_id, ifS.out_adr, ifS.out_bankSel, ifS.in_ready);
      end
    end
    ifS.out_ready = 1'b1;
    #1;
    checks++;
    if (ifS.in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: in_ready=%b, required 1", ifS.in_ready);
    end
    exp_q.push_back({2'd1, 4'd11});
    exp_q.push_back({2'd2, 4'd12});
    @(negedge clk);
    ifS.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ifS.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL drain_dup_%0d: extra output id=%0d", k, ifS.out_id);
        end else if ({ifS.out_bankSel, ifS.out_id} !== exp_q[0]) begin
          errors++;
          $display("FAIL drain_order_%0d: bank=%0d id=%0d, required bank=%0d id=%0d",
                   k, ifS.out_bankSel, ifS.out_id, exp_q[0][5:4], exp_q[0][3:0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || busyS !== 1'b0) begin
      errors++; $display("FAIL drain_complete: %0d lost, busy=%b, required 0 lost busy=0", exp_q.size(), busyS);
      exp_q.delete();
    end
  endtask

  task automatic test_array_mode();
    ifA.in_valid = 1'b1; ifA.in_adr = 32'h1234; ifA.in_id = 4'd9; ifA.in_we = 1'b1;
    @(negedge clk);
    ifA.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifA.out_valid, ifA.out_partIdx, ifA.out_miss, ifA.out_bankSel, ifA.out_id, ifA.out_we}
        !== {1'b1, 2'd0, 1'b0, 2'd1, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL array_mode: v=%b idx=%0d miss=%b bank=%0d id=%0d we=%b, required v=1 idx=0 miss=0 bank=1 id=9 we=1",
               ifA.out_valid, ifA.out_partIdx, ifA.out_miss, ifA.out_bankSel, ifA.out_id, ifA.out_we);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    ifS.in_valid = 1'b1; ifS.in_adr = 32'h0020; ifS.in_id = 4'd1; ifS.in_we = 1'b0;
    @(negedge clk);
    ifS.in_adr = 32'h0024; ifS.in_id = 4'd2;
    @(negedge clk);
    ifS.in_valid = 1'b0;
    checks++;
    if ({ifS.out_valid, busyS} !== 2'b11) begin
      errors++; $display("FAIL inflight_before_rst: v=%b busy=%b, required v=1 busy=1", ifS.out_valid, busyS);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ifS.out_valid, busyS} !== 2'b00) begin
      errors++; $display("FAIL async_rst: v=%b busy=%b, required v=0 busy=0", ifS.out_valid, busyS);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({ifS.out_valid, busyS} !== 2'b00) begin
        errors++; $display("FAIL stale_after_rst_%0d: v=%b busy=%b, required v=0 busy=0", k, ifS.out_valid, busyS);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_part(i, 32'h0, 32'h0);
    partEn = 4'b0000;
    ifS.in_valid = 1'b0; ifS.in_adr = '0; ifS.in_we = 1'b0; ifS.in_id = '0; ifS.out_ready = 1'b1;
    ifA.in_valid = 1'b0; ifA.in_adr = '0; ifA.in_we = 1'b0; ifA.in_id = '0; ifA.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_lookup();
    test_overlap();
    test_back_to_back();
    test_stall();
    test_array_mode();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/xcache_req_route.md
Name: xcache_req_route

Overview:
- Two-stage pipelined request router directly upstream of the xcache bank-address calculator.
- Accepts global-address requests from the core side and resolves the partition index by range lookup.
- Computes the bank select and presents a registered {adr, partIdx, bankSel, miss, id, we} bundle.
- The downstream bank-address stage consumes this bundle combinationally.
- Valid/ready on both sides, full throughput of 1 request/cycle.

Parameters:
- RANGE_TYPE, "SCALAR", "SCALAR" | "ARRAY" | "CYCLIC"; selects lookup and bank-select rule.
- NUM_BANK, 4, number of banks; power of two, 1..16.
- ID_W, 4, request tag width carried unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_adr  in  XMEM_AW  global byte address
- in_we  in  1  write flag, passed through
- in_id  in  ID_W  tag, passed through
- rangeStart  in  XMEM_AW x MAX_PARTITION  partition base (inclusive), from RISC config
- rangeEnd  in  XMEM_AW x MAX_PARTITION  partition limit (exclusive)
- partEn  in  MAX_PARTITION  per-partition enable
- out_valid  out  1  routed request valid
- out_ready  in  1  downstream accept
- out_adr  out  XMEM_AW  registered address
- out_partIdx  out  LOG2_MAX_PARTITION  resolved partition
- out_bankSel  out  $clog2(NUM_BANK) (min 1)  target bank
- out_miss  out  1  no enabled partition matched
- out_we  out  1  passthrough
- out_id  out  ID_W  passthrough
- busy  out  1  any pipeline stage holds a valid request

Behaviour:
- Reset is asynchronous and active-high on rst. All stage valids, out_valid, out_adr, out_partIdx, out_bankSel, out_miss, out_we and out_id are cleared to 0.
- in_ready is 1 after reset, since the pipeline is empty.
- Stage 1 (S1) registers in_adr, in_we and in_id.
- S1 also registers the match vector: m[i] = partEn[i] & (in_adr >= rangeStart[i]) & (in_adr < rangeEnd[i]).
- Stage 2 (S2) resolves partIdx as the lowest i with m[i]=1.
  - Priority encoding: overlapping ranges resolve to the lower index.
  - If m==0: partIdx=0 and miss=1.
- Bank select, computed in S2 and registered into the output register:
  - SCALAR: bankSel = (adr>>2) % NUM_BANK, which equals adr[2 +: log2 NUM_BANK]. Word interleave, consistent with the downstream ((adr>>2)/NUM_BANK)<<2 in-bank mapping.
  - ARRAY/CYCLIC: partIdx is forced to 0 and miss to 0 (no partitioning); bankSel = adr[2 +: log2 NUM_BANK].
  - NUM_BANK=1: bankSel=0.
- Latency: accept in cycle N gives out_valid in cycle N+2 when out_ready is held high.
- Handshake: each stage loads when it is empty or its content is being consumed in the same cycle.
  - in_ready = !s1_v | (s1_v & (!s2_v | (out_valid & out_ready))).
  - No combinational path from in_valid to out_valid.
  - The out_ready to in_ready path is allowed, at one AND-OR depth.
- Stall: when out_valid & !out_ready, all out_* are held stable, and S1 holds if full.
- Back-to-back: sustained in_valid with out_ready=1 moves 1 request/cycle with no bubbles.
- Simultaneous enqueue and dequeue on a full pipeline shifts all stages in the same cycle; nothing is dropped or duplicated.
- Config coherency: rangeStart/rangeEnd/partEn are sampled in S1 only. Software changes config only while busy=0; behaviour for changes during busy=1 is undefined except that no request is lost.
- Address compare is unsigned, full XMEM_AW width. rangeEnd=0 means an empty range (never matches).
- Reset mid-operation drops all in-flight requests; out_valid falls asynchronously.
- Ordering is strict FIFO; out_id order equals accept order.

Decomposition:
- Add to xcache_param_pkg: the RANGE_TYPE string constants and a typedef struct route_req_t {adr, we, id}.
- Natural sub-module: xcache_part_prienc, the MAX_PARTITION-to-index priority encoder with a miss output, also reusable by the write-back path.
- Everything else is in this module.

Test Plan:
- Reset, then SCALAR with NUM_BANK=4; part0 = [0x0000,0x1000), part1 = [0x1000,0x2000), both enabled. Send adr=0x1008, id=3 -> two cycles later out_valid=1, partIdx=1, bankSel=2, miss=0, id=3.
- Send adr=0x3000 -> out_miss=1, partIdx=0.
- Disable part1 and send 0x1004 -> miss=1.
- Overlap: part0 = [0x0,0x2000), part1 = [0x1000,0x2000). Send adr=0x1800 -> partIdx=0.
- Stream 8 requests, adr=0x0,0x4,…,0x1C, with out_ready=1 -> outputs on 8 consecutive cycles, bankSel=0,1,2,3,0,1,2,3, in order.
- Hold out_ready=0 while sending 3 requests -> third request sees in_ready=0; out_* stable.
  - Raise out_ready -> all 3 drain in order, none lost or duplicated.
- ARRAY mode with adr=0x1234, NUM_BANK=4 -> partIdx=0, miss=0, bankSel=1.
- Assert rst while 2 requests are in flight -> out_valid=0 immediately; busy=0; no stale output after rst falls.
